// File: rtl/hyper_cfg_sequencer.sv
// Boot-time configuration sequencer for a HyperBus config port.
// Waits for startup, replays a fixed write list, then bridges host register accesses with a per-access timeout.
module hyper_cfg_sequencer #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned NumInit       = 4,
    parameter logic [NumInit-1:0][AddrWidth-1:0] InitAddr = '0,
    parameter logic [NumInit-1:0][31:0]          InitData = '0,
    parameter int unsigned StartupCycles = 60000,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 host_valid_i,
    input  logic [AddrWidth-1:0] host_addr_i,
    input  logic                 host_write_i,
    input  logic [31:0]          host_wdata_i,
    input  logic [3:0]           host_wstrb_i,
    output logic                 host_ready_o,
    output logic [31:0]          host_rdata_o,
    output logic                 host_error_o,
    output logic                 cfg_valid_o,
    output logic [AddrWidth-1:0] cfg_addr_o,
    output logic                 cfg_write_o,
    output logic [31:0]          cfg_wdata_o,
    output logic [3:0]           cfg_wstrb_o,
    input  logic                 cfg_ready_i,
    input  logic [31:0]          cfg_rdata_i,
    input  logic                 cfg_error_i,
    output logic                 init_done_o,
    output logic                 init_err_o
);

    localparam int unsigned MaxCnt = (StartupCycles > TimeoutCycles) ? StartupCycles : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = (NumInit > 1) ? $clog2(NumInit) : 1;
    localparam logic [CntW-1:0] StartupLast = CntW'(StartupCycles - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};
    localparam logic [IdxW-1:0] IdxLast     = IdxW'(NumInit - 1);
    localparam logic [31:0]     AbortData   = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        WAIT_STARTUP,
        INIT_ISSUE,
        HOST_IDLE,
        HOST_ISSUE
    } state_e;

    state_e                state_reg, state_next;
    logic [CntW-1:0]       cnt_reg, cnt_next;
    logic [IdxW-1:0]       idx_reg, idx_next;
    logic                  cfg_valid_reg, cfg_valid_next;
    logic [AddrWidth-1:0]  host_addr_reg, host_addr_next;
    logic                  host_write_reg, host_write_next;
    logic [31:0]           host_wdata_reg, host_wdata_next;
    logic [3:0]            host_wstrb_reg, host_wstrb_next;
    logic                  host_ready_reg, host_ready_next;
    logic                  host_ready_d_reg, host_ready_d_next;
    logic [31:0]           host_rdata_reg, host_rdata_next;
    logic                  host_error_reg, host_error_next;
    logic                  init_done_reg, init_done_next;
    logic                  init_err_reg, init_err_next;

    logic [AddrWidth-1:0]  init_addr [NumInit];
    logic [31:0]           init_data [NumInit];

    generate
        for (genvar gi = 0; gi < NumInit; gi++) begin : g_init_table
            assign init_addr[gi] = InitAddr[gi];
            assign init_data[gi] = InitData[gi];
        end
    endgenerate

    logic            cfg_accept;
    logic            cfg_timeout;
    logic            host_holdoff;
    logic [CntW-1:0] cnt_sat_inc;

    // Ready is only honoured while a request is actually on the bus.
    assign cfg_accept   = cfg_valid_reg && cfg_ready_i;
    assign cfg_timeout  = cfg_valid_reg && !cfg_ready_i && (cnt_reg == TimeoutLast);
    assign host_holdoff = host_ready_reg || host_ready_d_reg;
    assign cnt_sat_inc  = (cnt_reg == CntMax) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= WAIT_STARTUP;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            cfg_valid_reg    <= 1'b0;
            host_addr_reg    <= '0;
            host_write_reg   <= 1'b0;
            host_wdata_reg   <= '0;
            host_wstrb_reg   <= '0;
            host_ready_reg   <= 1'b0;
            host_ready_d_reg <= 1'b0;
            host_rdata_reg   <= '0;
            host_error_reg   <= 1'b0;
            init_done_reg    <= 1'b0;
            init_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            idx_reg          <= idx_next;
            cfg_valid_reg    <= cfg_valid_next;
            host_addr_reg    <= host_addr_next;
            host_write_reg   <= host_write_next;
            host_wdata_reg   <= host_wdata_next;
            host_wstrb_reg   <= host_wstrb_next;
            host_ready_reg   <= host_ready_next;
            host_ready_d_reg <= host_ready_d_next;
            host_rdata_reg   <= host_rdata_next;
            host_error_reg   <= host_error_next;
            init_done_reg    <= init_done_next;
            init_err_reg     <= init_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        idx_next          = idx_reg;
        cfg_valid_next    = cfg_valid_reg;
        host_addr_next    = host_addr_reg;
        host_write_next   = host_write_reg;
        host_wdata_next   = host_wdata_reg;
        host_wstrb_next   = host_wstrb_reg;
        host_ready_next   = 1'b0;
        host_ready_d_next = host_ready_reg;
        host_rdata_next   = host_rdata_reg;
        host_error_next   = host_error_reg;
        init_done_next    = init_done_reg;
        init_err_next     = init_err_reg;

        unique case (state_reg)
            WAIT_STARTUP: begin
                if (cnt_reg == StartupLast) begin
                    state_next     = INIT_ISSUE;
                    cnt_next       = '0;
                    idx_next       = '0;
                    cfg_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt_sat_inc;
                end
            end

            INIT_ISSUE: begin
                // A timed-out write leaves a one-cycle gap before the next entry goes out.
                if (!cfg_valid_reg) begin
                    cfg_valid_next = 1'b1;
                end else if (cfg_accept || cfg_timeout) begin
                    cnt_next = '0;
                    if (cfg_timeout || cfg_error_i) begin
                        init_err_next = 1'b1;
                    end
                    if (cfg_timeout) begin
                        cfg_valid_next = 1'b0;
                    end
                    if (idx_reg == IdxLast) begin
                        state_next     = HOST_IDLE;
                        init_done_next = 1'b1;
                        cfg_valid_next = 1'b0;
                        idx_next       = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_sat_inc;
                end
            end

            HOST_IDLE: begin
                if (host_valid_i && !host_holdoff) begin
                    state_next      = HOST_ISSUE;
                    cnt_next        = '0;
                    host_addr_next  = host_addr_i;
                    host_write_next = host_write_i;
                    host_wdata_next = host_wdata_i;
                    host_wstrb_next = host_wstrb_i;
                end
            end

            HOST_ISSUE: begin
                if (!cfg_valid_reg) begin
                    cfg_valid_next = 1'b1;
                end else if (cfg_accept) begin
                    state_next      = HOST_IDLE;
                    cfg_valid_next  = 1'b0;
                    host_ready_next = 1'b1;
                    host_rdata_next = host_write_reg ? 32'h0 : cfg_rdata_i;
                    host_error_next = cfg_error_i;
                end else if (cfg_timeout) begin
                    state_next      = HOST_IDLE;
                    cfg_valid_next  = 1'b0;
                    host_ready_next = 1'b1;
                    host_rdata_next = AbortData;
                    host_error_next = 1'b1;
                end else begin
                    cnt_next = cnt_sat_inc;
                end
            end

            default: begin
                state_next = WAIT_STARTUP;
            end
        endcase
    end

    // Request fields read as zero whenever no request is on the bus.
    always_comb begin
        cfg_addr_o  = '0;
        cfg_write_o = 1'b0;
        cfg_wdata_o = '0;
        cfg_wstrb_o = '0;
        if (cfg_valid_reg) begin
            if (state_reg == INIT_ISSUE) begin
                cfg_addr_o  = init_addr[idx_reg];
                cfg_write_o = 1'b1;
                cfg_wdata_o = init_data[idx_reg];
                cfg_wstrb_o = 4'hF;
            end else begin
                cfg_addr_o  = host_addr_reg;
                cfg_write_o = host_write_reg;
                cfg_wdata_o = host_wdata_reg;
                cfg_wstrb_o = host_wstrb_reg;
            end
        end
    end

    assign cfg_valid_o  = cfg_valid_reg;
    assign host_ready_o = host_ready_reg;
    assign host_rdata_o = host_rdata_reg;
    assign host_error_o = host_error_reg;
    assign init_done_o  = init_done_reg;
    assign init_err_o   = init_err_reg;

endmodule

// File: tb/tb_hyper_cfg_sequencer.sv
// Directed bench for hyper_cfg_sequencer: a downstream responder plus scoreboards
// for the cfg-port transactions and the host completions.
module tb_hyper_cfg_sequencer;

    localparam int AW = 48;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } cfg_txn_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } host_rsp_t;

    logic          clk;
    logic          rst_ni;
    logic          host_valid_i;
    logic [AW-1:0] host_addr_i;
    logic          host_write_i;
    logic [31:0]   host_wdata_i;
    logic [3:0]    host_wstrb_i;
    logic          host_ready_o;
    logic [31:0]   host_rdata_o;
    logic          host_error_o;
    logic          cfg_valid_o;
    logic [AW-1:0] cfg_addr_o;
    logic          cfg_write_o;
    logic [31:0]   cfg_wdata_o;
    logic [3:0]    cfg_wstrb_o;
    logic          cfg_ready_i;
    logic [31:0]   cfg_rdata_i;
    logic          cfg_error_i;
    logic          init_done_o;
    logic          init_err_o;

    hyper_cfg_sequencer #(
        .AddrWidth    (AW),
        .NumInit      (2),
        .InitAddr     ({48'h0000_00C0_0004, 48'h0000_00C0_0000}),
        .InitData     ({32'hBEEF_0002, 32'hCAFE_0001}),
        .StartupCycles(10),
        .TimeoutCycles(5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .host_valid_i(host_valid_i),
        .host_addr_i (host_addr_i),
        .host_write_i(host_write_i),
        .host_wdata_i(host_wdata_i),
        .host_wstrb_i(host_wstrb_i),
        .host_ready_o(host_ready_o),
        .host_rdata_o(host_rdata_o),
        .host_error_o(host_error_o),
        .cfg_valid_o (cfg_valid_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_write_o (cfg_write_o),
        .cfg_wdata_o (cfg_wdata_o),
        .cfg_wstrb_o (cfg_wstrb_o),
        .cfg_ready_i (cfg_ready_i),
        .cfg_rdata_i (cfg_rdata_i),
        .cfg_error_i (cfg_error_i),
        .init_done_o (init_done_o),
        .init_err_o  (init_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    cfg_txn_t  cfg_q[$];
    host_rsp_t host_q[$];

    // Responder knobs, written only by the main sequence.
    bit            ds_always  = 1'b0;
    bit            ds_stuck   = 1'b0;
    int            ds_wait    = 0;
    bit            ds_err_en  = 1'b0;
    logic [AW-1:0] ds_err_addr = '0;

    int last_run = 0;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic cfg_txn_t mk_cfg(input logic [AW-1:0] a, input logic w,
                                        input logic [31:0] d, input logic [3:0] s);
        cfg_txn_t t;
        t.addr  = a;
        t.write = w;
        t.wdata = d;
        t.wstrb = s;
        return t;
    endfunction

    // Downstream responder and both scoreboards, evaluated on the falling edge.
    initial begin
        bit prev_valid;
        bit prev_ready;
        int vcnt;
        int run;
        cfg_txn_t  et;
        host_rsp_t er;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        vcnt        = 0;
        run         = 0;
        cfg_ready_i = 1'b0;
        cfg_error_i = 1'b0;
        cfg_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (cfg_valid_o) begin
                if (!prev_valid || prev_ready) vcnt = 0;
                else vcnt++;
                run++;
            end else begin
                if (run > 0) last_run = run;
                run  = 0;
                vcnt = 0;
            end
            cfg_ready_i = ds_always || (cfg_valid_o && !ds_stuck && (vcnt >= ds_wait));
            cfg_rdata_i = cfg_addr_o[31:0];
            cfg_error_i = cfg_ready_i && ds_err_en && cfg_valid_o && (cfg_addr_o == ds_err_addr);
            prev_valid  = cfg_valid_o;
            prev_ready  = cfg_ready_i;

            if (cfg_valid_o && cfg_ready_i) begin
                chk("cfg_txn_expected", 64'(cfg_q.size() != 0), 64'(1));
                if (cfg_q.size() != 0) begin
                    et = cfg_q.pop_front();
                    chk("cfg_addr",  64'(cfg_addr_o),  64'(et.addr));
                    chk("cfg_write", 64'(cfg_write_o), 64'(et.write));
                    chk("cfg_wdata", 64'(cfg_wdata_o), 64'(et.wdata));
                    chk("cfg_wstrb", 64'(cfg_wstrb_o), 64'(et.wstrb));
                    $display("cfg  txn addr=%h write=%0d wdata=%h wstrb=%h err=%0d",
                             cfg_addr_o, cfg_write_o, cfg_wdata_o, cfg_wstrb_o, cfg_error_i);
                end
            end

            if (host_ready_o) begin
                chk("host_rsp_expected", 64'(host_q.size() != 0), 64'(1));
                if (host_q.size() != 0) begin
                    er = host_q.pop_front();
                    chk("host_rdata",      64'(host_rdata_o), 64'(er.rdata));
                    chk("host_error",      64'(host_error_o), 64'(er.err));
                    chk("host_after_init", 64'(init_done_o),  64'(1));
                    $display("host rsp rdata=%h error=%0d", host_rdata_o, host_error_o);
                end
            end
        end
    end

    task automatic host_access(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] s, input logic [31:0] exp_rdata, input logic exp_err,
                               input bit push_cfg, input int hold_extra, output int lat);
        host_rsp_t r;
        if (push_cfg) cfg_q.push_back(mk_cfg(a, w, d, s));
        r.rdata = exp_rdata;
        r.err   = exp_err;
        host_q.push_back(r);
        host_addr_i  = a;
        host_write_i = w;
        host_wdata_i = d;
        host_wstrb_i = s;
        host_valid_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!host_ready_o && lat < 200);
        chk("host_ready_seen", 64'(host_ready_o), 64'(1));
        repeat (hold_extra) @(negedge clk);
        host_valid_i = 1'b0;
    endtask

    initial begin
        int k;
        int kd;
        int kr;
        int lat;

        rst_ni       = 1'b0;
        host_valid_i = 1'b0;
        host_addr_i  = '0;
        host_write_i = 1'b0;
        host_wdata_i = '0;
        host_wstrb_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_cfg_valid",  64'(cfg_valid_o),  64'(0));
        chk("rst_host_ready", 64'(host_ready_o), 64'(0));
        chk("rst_init_done",  64'(init_done_o),  64'(0));
        chk("rst_init_err",   64'(init_err_o),   64'(0));
        chk("rst_host_rdata", 64'(host_rdata_o), 64'(0));
        chk("rst_cfg_addr",   64'(cfg_addr_o),   64'(0));

        // Boot with an always-ready downstream and a host read already pending.
        ds_always = 1'b1;
        cfg_q.push_back(mk_cfg(48'h0000_00C0_0000, 1'b1, 32'hCAFE_0001, 4'hF));
        cfg_q.push_back(mk_cfg(48'h0000_00C0_0004, 1'b1, 32'hBEEF_0002, 4'hF));
        cfg_q.push_back(mk_cfg(48'h0000_1234_5678, 1'b0, 32'h0, 4'h0));
        host_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        host_addr_i  = 48'h0000_1234_5678;
        host_write_i = 1'b0;
        host_wdata_i = '0;
        host_wstrb_i = '0;
        host_valid_i = 1'b1;
        rst_ni       = 1'b1;

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cfg_valid_o && k < 100);
        chk("first_cfg_cycle", 64'(k), 64'(10));
        while (!init_done_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        kd = k;
        chk("init_done", 64'(init_done_o), 64'(1));
        chk("init_err",  64'(init_err_o),  64'(0));
        while (!host_ready_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        kr = k;
        host_valid_i = 1'b0;
        chk("read_latency_after_init", 64'(kr - kd), 64'(3));
        @(negedge clk);
        chk("rdata_hold",       64'(host_rdata_o), 64'(32'h1234_5678));
        chk("host_ready_pulse", 64'(host_ready_o), 64'(0));
        ds_always = 1'b0;
        repeat (3) @(negedge clk);
        chk("boot_cfg_q_empty", 64'(cfg_q.size()), 64'(0));

        // Zero-wait write; valid held across the two cycles the block must ignore.
        host_access(48'h0000_0000_0100, 1'b1, 32'hDEAD_0001, 4'h3, 32'h0, 1'b0, 1'b1, 2, lat);
        chk("write_latency", 64'(lat), 64'(3));
        repeat (4) @(negedge clk);
        chk("holdoff_cfg_q_empty",  64'(cfg_q.size()),  64'(0));
        chk("holdoff_host_q_empty", 64'(host_q.size()), 64'(0));

        // Back-to-back accesses against a two-cycle downstream wait.
        ds_wait = 2;
        host_access(48'h0000_5555_0200, 1'b0, 32'h0, 4'hF, 32'h5555_0200, 1'b0, 1'b1, 0, lat);
        chk("wait2_latency", 64'(lat), 64'(5));
        host_access(48'h0000_0000_0300, 1'b1, 32'h1357_9BDF, 4'hC, 32'h0, 1'b0, 1'b1, 0, lat);
        host_access(48'h0000_AAAA_0400, 1'b0, 32'h0, 4'h1, 32'hAAAA_0400, 1'b0, 1'b1, 0, lat);
        repeat (4) @(negedge clk);
        chk("b2b_cfg_q_empty",  64'(cfg_q.size()),  64'(0));
        chk("b2b_host_q_empty", 64'(host_q.size()), 64'(0));
        ds_wait = 0;

        // Downstream never answers: the access must abort after the timeout.
        ds_stuck = 1'b1;
        host_access(48'h0000_0000_0600, 1'b1, 32'h0BAD_F00D, 4'hF, 32'hBADC_AB1E, 1'b1, 1'b0, 1, lat);
        chk("timeout_latency",      64'(lat),      64'(7));
        chk("timeout_valid_cycles", 64'(last_run), 64'(5));

        // Reset in the middle of a stalled host read.
        host_addr_i  = 48'h0000_0000_0700;
        host_write_i = 1'b0;
        host_wdata_i = '0;
        host_wstrb_i = 4'hF;
        host_valid_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cfg_valid_o && k < 20);
        chk("midreset_issue_seen", 64'(cfg_valid_o), 64'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_cfg_valid",  64'(cfg_valid_o),  64'(0));
        chk("async_rst_host_ready", 64'(host_ready_o), 64'(0));
        chk("async_rst_init_done",  64'(init_done_o),  64'(0));
        chk("async_rst_host_rdata", 64'(host_rdata_o), 64'(0));
        chk("async_rst_cfg_addr",   64'(cfg_addr_o),   64'(0));
        host_valid_i = 1'b0;
        ds_stuck     = 1'b0;

        // Restart with the first init write answered with an error.
        ds_err_en   = 1'b1;
        ds_err_addr = 48'h0000_00C0_0000;
        cfg_q.push_back(mk_cfg(48'h0000_00C0_0000, 1'b1, 32'hCAFE_0001, 4'hF));
        cfg_q.push_back(mk_cfg(48'h0000_00C0_0004, 1'b1, 32'hBEEF_0002, 4'hF));
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cfg_valid_o && k < 100);
        chk("restart_first_cfg_cycle", 64'(k), 64'(10));
        while (!init_done_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("err_init_done", 64'(init_done_o), 64'(1));
        chk("err_init_err",  64'(init_err_o),  64'(1));
        repeat (2) @(negedge clk);
        chk("err_init_cfg_q_empty", 64'(cfg_q.size()), 64'(0));

        host_access(48'h0000_7777_0800, 1'b0, 32'h0, 4'hF, 32'h7777_0800, 1'b0, 1'b1, 0, lat);
        chk("post_restart_latency", 64'(lat), 64'(3));
        repeat (3) @(negedge clk);
        chk("final_host_q_empty", 64'(host_q.size()), 64'(0));
        chk("final_init_err_sticky", 64'(init_err_o), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
